// File: rtl/traffic_light_pkg.sv
// Shared state encoding and lamp decode for the two-road intersection controller.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        CLR_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        CLR_BA   = 3'd5,
        FLASH    = 3'd6
    } phase_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    typedef struct packed {
        lamp_t roadA;
        lamp_t roadB;
    } lampPair_t;

    localparam lamp_t LAMP_OFF    = 3'b000;
    localparam lamp_t LAMP_RED    = 3'b100;
    localparam lamp_t LAMP_YELLOW = 3'b010;
    localparam lamp_t LAMP_GREEN  = 3'b001;

    // Unused encoding 7 falls back to all-red so a corrupted state never shows a go signal.
    function automatic lampPair_t decodeLamps(input phase_t state, input logic flashOn);
        lampPair_t lamps;
        lamps.roadA = LAMP_RED;
        lamps.roadB = LAMP_RED;
        case (state)
            A_GREEN:  lamps.roadA = LAMP_GREEN;
            A_YELLOW: lamps.roadA = LAMP_YELLOW;
            B_GREEN:  lamps.roadB = LAMP_GREEN;
            B_YELLOW: lamps.roadB = LAMP_YELLOW;
            FLASH: begin
                lamps.roadA = flashOn ? LAMP_YELLOW : LAMP_OFF;
                lamps.roadB = flashOn ? LAMP_YELLOW : LAMP_OFF;
            end
            default: begin
                lamps.roadA = LAMP_RED;
                lamps.roadB = LAMP_RED;
            end
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating per-state cycle counter; cleared on the edge where the controller changes state.
module phase_timer #(
    parameter int CNT_W        = 8,
    parameter int GREEN_MIN    = 5,
    parameter int GREEN_MAX    = 12,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             minDone,
    output logic             maxDone,
    output logic             yellowDone,
    output logic             allRedDone
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALL_RED_TIME - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    // Each compare fires on the last cycle of its interval so the state lasts exactly that many cycles.
    assign minDone    = (count >= MIN_LAST);
    assign maxDone    = (count >= MAX_LAST);
    assign yellowDone = (count >= YELLOW_LAST);
    assign allRedDone = (count >= ALLRED_LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: green min/max arbitration, all-red clearance, flashing-yellow maintenance.
module traffic_light_ctrl
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN    = 5,
    parameter int GREEN_MAX    = 12,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int FLASH_HALF   = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensorA,
    input  logic             sensorB,
    input  logic             flashMode,
    output logic             redLightA,
    output logic             yellowLightA,
    output logic             greenLightA,
    output logic             redLightB,
    output logic             yellowLightB,
    output logic             greenLightB,
    output logic [2:0]       phaseState,
    output logic [CNT_W-1:0] phaseCount
);

    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

    phase_t           state;
    phase_t           nextState;
    logic             stateChange;
    logic             flashOn;
    logic [CNT_W-1:0] flashCnt;
    logic             minDone;
    logic             maxDone;
    logic             yellowDone;
    logic             allRedDone;
    lampPair_t        lamps;

    phase_timer #(
        .CNT_W       (CNT_W),
        .GREEN_MIN   (GREEN_MIN),
        .GREEN_MAX   (GREEN_MAX),
        .YELLOW_TIME (YELLOW_TIME),
        .ALL_RED_TIME(ALL_RED_TIME)
    ) timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (stateChange),
        .count     (phaseCount),
        .minDone   (minDone),
        .maxDone   (maxDone),
        .yellowDone(yellowDone),
        .allRedDone(allRedDone)
    );

    // A keeps green without B demand; B yields after its minimum once its own demand is gone.
    always_comb begin
        nextState = state;
        case (state)
            A_GREEN:
                if (flashMode || (sensorB && minDone && (!sensorA || maxDone)))
                    nextState = A_YELLOW;
            A_YELLOW:
                if (yellowDone) nextState = CLR_AB;
            CLR_AB:
                if (allRedDone) nextState = flashMode ? FLASH : B_GREEN;
            B_GREEN:
                if (flashMode || (minDone && (!sensorB || (sensorA && maxDone))))
                    nextState = B_YELLOW;
            B_YELLOW:
                if (yellowDone) nextState = CLR_BA;
            CLR_BA:
                if (allRedDone) nextState = flashMode ? FLASH : A_GREEN;
            FLASH:
                if (!flashMode) nextState = CLR_BA;
            default:
                nextState = CLR_BA;
        endcase
    end

    assign stateChange = (nextState != state);

    // Flash phase starts lit on entry and is forced dark whenever the controller is outside FLASH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLR_BA;
            flashOn  <= 1'b0;
            flashCnt <= '0;
        end else begin
            state <= nextState;
            if (nextState == FLASH && state != FLASH) begin
                flashOn  <= 1'b1;
                flashCnt <= '0;
            end else if (nextState == FLASH) begin
                if (flashCnt == FLASH_LAST) begin
                    flashOn  <= ~flashOn;
                    flashCnt <= '0;
                end else begin
                    flashCnt <= flashCnt + 1'b1;
                end
            end else begin
                flashOn  <= 1'b0;
                flashCnt <= '0;
            end
        end
    end

    assign lamps        = decodeLamps(state, flashOn);
    assign redLightA    = lamps.roadA.red;
    assign yellowLightA = lamps.roadA.yellow;
    assign greenLightA  = lamps.roadA.green;
    assign redLightB    = lamps.roadB.red;
    assign yellowLightB = lamps.roadB.yellow;
    assign greenLightB  = lamps.roadB.green;
    assign phaseState   = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: expected state/lamps/count queued per cycle, compared at negedge.
module tb_traffic_light_ctrl;

    localparam logic [2:0] S_AG = 3'd0, S_AY = 3'd1, S_CAB = 3'd2, S_BG = 3'd3,
                           S_BY = 3'd4, S_CBA = 3'd5, S_FL = 3'd6;
    localparam logic [5:0] L_AG = 6'b001_100, L_AY = 6'b010_100, L_RR = 6'b100_100,
                           L_BG = 6'b100_001, L_BY = 6'b100_010,
                           L_FON = 6'b010_010, L_FOFF = 6'b000_000;

    typedef struct packed {
        logic [2:0] state;
        logic [5:0] lamps;
        logic [7:0] pc;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensorA;
    logic       sensorB;
    logic       flashMode;
    logic       redLightA, yellowLightA, greenLightA;
    logic       redLightB, yellowLightB, greenLightB;
    logic [2:0] phaseState;
    logic [7:0] phaseCount;

    expect_t    sbQueue[$];
    int         checkCount = 0;
    int         errorCount = 0;
    int         testId     = 0;
    logic       invOn      = 1'b0;

    traffic_light_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .sensorA     (sensorA),
        .sensorB     (sensorB),
        .flashMode   (flashMode),
        .redLightA   (redLightA),
        .yellowLightA(yellowLightA),
        .greenLightA (greenLightA),
        .redLightB   (redLightB),
        .yellowLightB(yellowLightB),
        .greenLightB (greenLightB),
        .phaseState  (phaseState),
        .phaseCount  (phaseCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic f);
        sensorA   = a;
        sensorB   = b;
        flashMode = f;
    endtask

    task automatic expectPhase(input logic [2:0] st, input logic [5:0] lp, input int n, input int startPc);
        for (int i = 0; i < n; i++)
            sbQueue.push_back('{state: st, lamps: lp, pc: 8'(startPc + i)});
    endtask

    task automatic runScoreboard();
        expect_t e;
        while (sbQueue.size() > 0) begin
            @(negedge clk);
            e = sbQueue.pop_front();
            checkOutput($sformatf("t%0d state", testId), {29'd0, phaseState}, {29'd0, e.state});
            checkOutput($sformatf("t%0d lamps", testId),
                        {26'd0, redLightA, yellowLightA, greenLightA, redLightB, yellowLightB, greenLightB},
                        {26'd0, e.lamps});
            checkOutput($sformatf("t%0d phaseCount", testId), {24'd0, phaseCount}, {24'd0, e.pc});
        end
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        repeat (cycles - 1) @(negedge clk);
        expectPhase(S_CBA, L_RR, 1, 0);
        runScoreboard();
        reset = 1'b0;
    endtask

    // Outside FLASH no road may be non-red while the other is, and each road shows exactly one lamp.
    always @(negedge clk) begin
        if (invOn && phaseState != S_FL) begin
            checkOutput("invariant",
                        {29'd0,
                         (yellowLightA | greenLightA) & (yellowLightB | greenLightB),
                         ($countones({redLightA, yellowLightA, greenLightA}) == 1),
                         ($countones({redLightB, yellowLightB, greenLightB}) == 1)},
                        32'b011);
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0);

        testId = 1;
        doReset(3);
        invOn = 1'b1;
        expectPhase(S_AG, L_AG, 55, 0);
        runScoreboard();

        testId = 2;
        doReset(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectPhase(S_AG, L_AG, 5, 0);
        expectPhase(S_AY, L_AY, 2, 0);
        expectPhase(S_CAB, L_RR, 1, 0);
        runScoreboard();
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectPhase(S_BG, L_BG, 5, 0);
        expectPhase(S_BY, L_BY, 2, 0);
        expectPhase(S_CBA, L_RR, 1, 0);
        expectPhase(S_AG, L_AG, 3, 0);
        runScoreboard();

        testId = 3;
        doReset(1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectPhase(S_AG, L_AG, 12, 0);
        expectPhase(S_AY, L_AY, 2, 0);
        expectPhase(S_CAB, L_RR, 1, 0);
        expectPhase(S_BG, L_BG, 12, 0);
        expectPhase(S_BY, L_BY, 2, 0);
        expectPhase(S_CBA, L_RR, 1, 0);
        expectPhase(S_AG, L_AG, 12, 0);
        expectPhase(S_AY, L_AY, 2, 0);
        expectPhase(S_CAB, L_RR, 1, 0);
        runScoreboard();

        testId = 4;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectPhase(S_BG, L_BG, 3, 0);
        runScoreboard();
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectPhase(S_BG, L_BG, 2, 3);
        expectPhase(S_BY, L_BY, 2, 0);
        expectPhase(S_CBA, L_RR, 1, 0);
        expectPhase(S_AG, L_AG, 2, 0);
        runScoreboard();

        testId = 5;
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectPhase(S_AY, L_AY, 2, 0);
        expectPhase(S_CAB, L_RR, 1, 0);
        expectPhase(S_FL, L_FON, 4, 0);
        expectPhase(S_FL, L_FOFF, 4, 4);
        expectPhase(S_FL, L_FON, 4, 8);
        runScoreboard();
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectPhase(S_CBA, L_RR, 1, 0);
        expectPhase(S_AG, L_AG, 3, 0);
        runScoreboard();

        testId = 6;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectPhase(S_AG, L_AG, 2, 3);
        expectPhase(S_AY, L_AY, 2, 0);
        expectPhase(S_CAB, L_RR, 1, 0);
        runScoreboard();
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectPhase(S_BG, L_BG, 5, 0);
        expectPhase(S_BY, L_BY, 1, 0);
        runScoreboard();
        reset = 1'b1;
        expectPhase(S_CBA, L_RR, 1, 0);
        runScoreboard();
        reset = 1'b0;
        expectPhase(S_AG, L_AG, 2, 0);
        runScoreboard();

        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
